// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the pipelined immediate generator:
// immediate format codes and the RV32I opcodes that select them.
package imm_gen_pipe_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4,
    FMT_U = 3'd5,
    FMT_Z = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction side (in_*) and
// decoded-immediate side (out_*). The master is the environment that
// feeds instructions and consumes immediates; the slave is the pipe.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  logic [2:0]        out_fmt;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I immediate decoder: opcode -> format, immediate
// sign-extended from instr[31] to XLEN, illegal flag for unknown opcodes.
// IMMGEN_ZIMM_EN: when defined, CSR*I instructions (SYSTEM, instr[14]=1)
// yield FMT_Z with the zero-extended 5-bit zimm.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output fmt_e            o_fmt,
  output logic            o_illegal
);

  logic [31:0] w_imm32;

  // Select format and build the 32-bit immediate from the opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    w_imm32   = '0;
    o_fmt     = FMT_R;
    o_illegal = 1'b0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        o_fmt   = FMT_I;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OPC_SYSTEM: begin
`ifdef IMMGEN_ZIMM_EN
        if (i_instr[14]) begin
          o_fmt   = FMT_Z;
          w_imm32 = {27'b0, i_instr[19:15]};
        end else begin
          o_fmt   = FMT_I;
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        end
`else
        o_fmt   = FMT_I;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
`endif
      end
      OPC_STORE: begin
        o_fmt   = FMT_S;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OPC_BRANCH: begin
        o_fmt   = FMT_B;
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OPC_JAL: begin
        o_fmt   = FMT_J;
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        o_fmt   = FMT_U;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      OPC_OP: begin
        o_fmt   = FMT_R;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; zimm has bit 31 clear so it stays zero-extended.
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the RV32I immediate at the input
// and presents it from a registered main stage backed by one skid entry,
// so in_ready can be a pure register. Optional feature macro:
// IMMGEN_ZIMM_EN (CSR*I zimm decode, handled in imm_decode).
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_flush,
  imm_gen_pipe_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] w_imm;
  fmt_e            w_fmt;
  logic            w_illegal;
  entry_t          w_in_entry;

  entry_t r_main, r_skid, w_main_nxt, w_skid_nxt;
  logic   r_main_valid, r_skid_valid, r_in_ready;
  logic   w_main_valid_nxt, w_skid_valid_nxt;
  logic   w_in_fire, w_out_fire;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr   (bus.in_instr),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  assign w_in_entry = '{imm: w_imm, fmt: w_fmt, illegal: w_illegal, tag: bus.in_tag};
  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_main_valid & bus.out_ready;

  // Next-state for main/skid: refill main when it is empty or draining,
  // otherwise park the accepted input in the skid entry.
  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        // in_ready is low while skid is full, so no input competes here.
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_main_valid_nxt = w_in_fire;
        if (w_in_fire) w_main_nxt = w_in_entry;
      end
    end else if (w_in_fire) begin
      w_skid_nxt       = w_in_entry;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // State registers: reset clears everything, flush only drops entries.
  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      // NOTE: payload registers are reset only because the block must
      // present all-zero out_* after reset; flush leaves them untouched.
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_main_valid;
  assign bus.out_imm     = r_main.imm;
  assign bus.out_fmt     = r_main.fmt;
  assign bus.out_illegal = r_main.illegal;
  assign bus.out_tag     = r_main.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: table of known encodings on an
// XLEN=32 and an XLEN=64 instance, hand-written backpressure/flush/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush32;
  logic flush64;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush32), .bus(bus32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush64), .bus(bus64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode straight from the RV32I immediate rules, using signed
  // integer arithmetic; result is the 64-bit sign-extended immediate.
  function automatic void ref_dec(input logic [31:0] ins, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    int si;
    int r;
    si  = int'(ins);
    r   = 0;
    fmt = FMT_R;
    ill = 1'b0;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin fmt = FMT_I; r = si >>> 20; end
      7'b1110011: begin
`ifdef IMMGEN_ZIMM_EN
        if (ins[14]) begin fmt = FMT_Z; r = int'(ins[19:15]); end
        else begin fmt = FMT_I; r = si >>> 20; end
`else
        fmt = FMT_I; r = si >>> 20;
`endif
      end
      7'b0100011: begin fmt = FMT_S; r = (si >>> 25) * 32 + int'(ins[11:7]); end
      7'b1100011: begin
        fmt = FMT_B;
        r = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      7'b1101111: begin
        fmt = FMT_J;
        r = (si >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
      end
      7'b0110111, 7'b0010111: begin fmt = FMT_U; r = si & int'(32'hFFFF_F000); end
      7'b0110011: fmt = FMT_R;
      default: ill = 1'b1;
    endcase
    imm = 64'(longint'(r));
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  vec_t vecs[10];

  task automatic idle_inputs();
    bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_tag = '0; bus32.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_tag = '0; bus64.out_ready = 1'b0;
  endtask

  // Run the 32-bit pipe with out_ready=1 for n cycles; count presented entries.
  task automatic drain_count(input int n, output int seen);
    seen = 0;
    bus32.out_ready = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (bus32.out_valid) seen++;
      tick();
    end
  endtask

  initial begin
    int seen;
    logic [31:0] got_tag[$];
    int          got_cyc[$];
    exp_t        q[$];
    logic [6:0]  ops[11];

    vecs[0] = '{32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0}; // addi x1,x0,-1
    vecs[1] = '{32'hFE11_2E23, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S, 1'b0}; // sw x1,-4(x2)
    vecs[2] = '{32'h1234_52B7, 64'h0000_0000_1234_5000, FMT_U, 1'b0}; // lui 0x12345
    vecs[3] = '{32'h8000_02B7, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0}; // lui 0x80000
    vecs[4] = '{32'h0000_007F, 64'h0,                   FMT_R, 1'b1}; // unknown opcode
`ifdef IMMGEN_ZIMM_EN
    vecs[5] = '{32'hFFFF_D073, 64'h0000_0000_0000_001F, FMT_Z, 1'b0}; // csrrwi
`else
    vecs[5] = '{32'hFFFF_D073, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0}; // csrrwi
`endif
    vecs[6] = '{32'hFE00_0EE3, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0}; // beq x0,x0,-4
    vecs[7] = '{32'h0080_006F, 64'h0000_0000_0000_0008, FMT_J, 1'b0}; // jal x0,8
    vecs[8] = '{32'h0020_81B3, 64'h0,                   FMT_R, 1'b0}; // add x3,x1,x2
    vecs[9] = '{32'hFFFF_F017, 64'hFFFF_FFFF_FFFF_F000, FMT_U, 1'b0}; // auipc 0xFFFFF

    idle_inputs();
    flush32 = 1'b0;
    flush64 = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    check("rst_out_valid", 64'(bus32.out_valid), 64'(0));
    check("rst_in_ready",  64'(bus32.in_ready),  64'(1));
    check("rst_out_imm",   64'(bus32.out_imm),   64'(0));
    check("rst_out_tag",   64'(bus32.out_tag),   64'(0));
    check("rst64_out_valid", 64'(bus64.out_valid), 64'(0));

    // Known encodings through both widths, one-cycle latency from empty.
    for (int i = 0; i < 10; i++) begin
      bus32.in_valid = 1'b1; bus32.in_instr = vecs[i].instr; bus32.in_tag = 32'(i + 1);
      bus64.in_valid = 1'b1; bus64.in_instr = vecs[i].instr; bus64.in_tag = 32'(i + 1);
      bus32.out_ready = 1'b1; bus64.out_ready = 1'b1;
      tick();
      bus32.in_valid = 1'b0; bus64.in_valid = 1'b0;
      check($sformatf("vec%0d_valid32", i), 64'(bus32.out_valid), 64'(1));
      check($sformatf("vec%0d_imm32", i),   64'(bus32.out_imm),   64'(vecs[i].imm[31:0]));
      check($sformatf("vec%0d_fmt32", i),   64'(bus32.out_fmt),   64'(vecs[i].fmt));
      check($sformatf("vec%0d_ill32", i),   64'(bus32.out_illegal), 64'(vecs[i].ill));
      check($sformatf("vec%0d_tag32", i),   64'(bus32.out_tag),   64'(i + 1));
      check($sformatf("vec%0d_valid64", i), 64'(bus64.out_valid), 64'(1));
      check($sformatf("vec%0d_imm64", i),   bus64.out_imm,        vecs[i].imm);
      check($sformatf("vec%0d_fmt64", i),   64'(bus64.out_fmt),   64'(vecs[i].fmt));
      tick();
    end
    bus64.out_ready = 1'b0;

    // Backpressure: tags 1,2 accepted, 3 held off, then all drain in order.
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_instr = 32'h0010_0093; bus32.in_tag = 32'd1;
    tick();
    bus32.in_tag = 32'd2;
    tick();
    bus32.in_tag = 32'd3;
    check("bp_in_ready_low", 64'(bus32.in_ready), 64'(0));
    tick();
    check("bp_stall_tag", 64'(bus32.out_tag), 64'(1));
    bus32.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bit acc;
      acc = bus32.in_valid && bus32.in_ready;
      if (bus32.out_valid) begin
        got_tag.push_back(bus32.out_tag);
        got_cyc.push_back(c);
      end
      tick();
      if (acc) bus32.in_valid = 1'b0;
    end
    bus32.in_valid = 1'b0;
    check("bp_count", 64'(got_tag.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_order%0d", i), 64'(got_tag.size() > i ? got_tag[i] : 32'hDEAD), 64'(i + 1));
    end
    if (got_cyc.size() >= 3) begin
      check("bp_back_to_back", 64'(got_cyc[2] - got_cyc[0]), 64'(2));
    end else begin
      check("bp_back_to_back", 64'(got_cyc.size()), 64'(3));
    end

    // Flush with both entries full and a concurrent input.
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_tag = 32'd10;
    tick();
    bus32.in_tag = 32'd11;
    tick();
    bus32.in_tag = 32'd12; flush32 = 1'b1;
    tick();
    flush32 = 1'b0; bus32.in_valid = 1'b0;
    check("flush_full_valid", 64'(bus32.out_valid), 64'(0));
    check("flush_full_ready", 64'(bus32.in_ready),  64'(1));
    drain_count(5, seen);
    check("flush_full_nothing_out", 64'(seen), 64'(0));

    // Flush with only main full: the concurrent input is accepted-eligible but dropped.
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_tag = 32'd20;
    tick();
    bus32.in_tag = 32'd21; flush32 = 1'b1;
    tick();
    flush32 = 1'b0; bus32.in_valid = 1'b0;
    check("flush_half_valid", 64'(bus32.out_valid), 64'(0));
    check("flush_half_ready", 64'(bus32.in_ready),  64'(1));
    drain_count(5, seen);
    check("flush_half_nothing_out", 64'(seen), 64'(0));

    // Reset during a stall with both entries full.
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_instr = 32'hFFF0_0093; bus32.in_tag = 32'd30;
    tick();
    bus32.in_tag = 32'd31;
    tick();
    bus32.in_tag = 32'd32; rst = 1'b1;
    tick();
    rst = 1'b0; bus32.in_valid = 1'b0;
    check("rst_stall_valid", 64'(bus32.out_valid),   64'(0));
    check("rst_stall_ready", 64'(bus32.in_ready),    64'(1));
    check("rst_stall_imm",   64'(bus32.out_imm),     64'(0));
    check("rst_stall_fmt",   64'(bus32.out_fmt),     64'(0));
    check("rst_stall_ill",   64'(bus32.out_illegal), 64'(0));
    check("rst_stall_tag",   64'(bus32.out_tag),     64'(0));
    drain_count(5, seen);
    check("rst_stall_nothing_out", 64'(seen), 64'(0));

    // Randomized traffic against the queue model.
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011, 7'b0001111};
    begin
      bit          stalled_prev;
      logic [31:0] prev_imm;
      logic [31:0] prev_tag;
      stalled_prev = 1'b0;
      prev_imm = '0;
      prev_tag = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        logic [31:0] w;
        int          idx;
        bit          in_fire;
        bit          out_fire;
        w   = $urandom();
        idx = int'($urandom_range(0, 12));
        if (idx < 11) w[6:0] = ops[idx];
        bus32.in_valid  = ($urandom_range(0, 3) != 0);
        bus32.in_instr  = w;
        bus32.in_tag    = 32'(cyc + 1000);
        bus32.out_ready = ($urandom_range(0, 2) != 0);

        check("rnd_out_valid", 64'(bus32.out_valid), 64'(q.size() > 0));
        check("rnd_in_ready",  64'(bus32.in_ready),  64'(q.size() < 2));
        if (stalled_prev) begin
          check("rnd_stable_imm", 64'(bus32.out_imm), 64'(prev_imm));
          check("rnd_stable_tag", 64'(bus32.out_tag), 64'(prev_tag));
        end

        in_fire  = bus32.in_valid && bus32.in_ready;
        out_fire = bus32.out_valid && bus32.out_ready;
        if (out_fire && q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          check("rnd_imm", 64'(bus32.out_imm),     64'(e.imm[31:0]));
          check("rnd_fmt", 64'(bus32.out_fmt),     64'(e.fmt));
          check("rnd_ill", 64'(bus32.out_illegal), 64'(e.ill));
          check("rnd_tag", 64'(bus32.out_tag),     64'(e.tag));
        end
        if (in_fire) begin
          exp_t e;
          ref_dec(w, e.imm, e.fmt, e.ill);
          e.tag = bus32.in_tag;
          q.push_back(e);
        end
        stalled_prev = bus32.out_valid && !bus32.out_ready;
        prev_imm = bus32.out_imm;
        prev_tag = bus32.out_tag;
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational sign-extender.
- Decodes the immediate format directly from the 32-bit RV32I instruction word instead of taking an external format select.
- Sign-extends the immediate to XLEN bits and flags unknown opcodes.
- Output is registered behind a 2-entry skid buffer with valid/ready handshakes on both sides. Sits between fetch/decode and the execute operand mux.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (typically PC) carried alongside each instruction.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all buffered entries (redirect).
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept; driven from a register.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband passed through unchanged.
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  decoded format code (FMT_*).
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the presented entry.

Behaviour:
- Opcode decode on instr[6:0]:
  - I: 0000011, 0010011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - J: 1101111.
  - U: 0110111, 0010111.
  - R: 0110011.
  - Anything else: FMT_R, imm=0, illegal=1.
- Immediates per RV32I:
  - I: {instr[31:20]}.
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - U: {instr[31:12],12'b0}.
  - All formats, U included, sign-extended from instr[31] to XLEN. For XLEN=64, U is therefore sign-extended above bit 31.
  - R: imm=0.
- Storage: main register (drives out_*) plus one skid entry. Latency from accepted input to out_valid is 1 cycle when the pipe is empty.
- Input transfer: in_valid & in_ready.
- Output transfer: out_valid & out_ready.
- in_ready = !skid_full, registered.
- Main empty or draining this cycle: the accepted input loads main directly.
- Main full and not draining: the accepted input loads skid, and in_ready falls next cycle.
- On drain: skid moves to main and in_ready rises next cycle. Order is always preserved.
- Simultaneous accept and drain with skid empty: main is replaced, no bubble.
- out_* stay stable while out_valid=1 and out_ready=0.
- flush: next cycle out_valid=0, skid empty, in_ready=1. An input presented in the flush cycle is dropped.
- rst: same as flush. Additionally out_imm, out_fmt, out_illegal and out_tag are set to 0. Reset during a stall discards both entries. rst has priority over flush and over all transfers.

Optional Feature:
- Macro IMMGEN_ZIMM_EN.
- Defined: opcode 1110011 with instr[14]=1 (CSR*I) gives FMT_Z, with imm = zero-extended instr[19:15].
- Undefined: FMT_Z is never produced, and all 1110011 instructions decode as I-type.

Decomposition:
- Shared include param.v holds:
  - FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_J=4, FMT_U=5, FMT_Z=6.
  - OPC_* 7-bit opcode constants.
- One combinational sub-module, imm_decode (instr -> imm, fmt, illegal; parameter XLEN), instantiated once at the input. The skid/handshake logic lives in imm_gen_pipe.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, fmt=FMT_I, illegal=0.
- sw x1,-4(x2) (0xFE112E23) -> out_imm=0xFFFFFFFC, fmt=FMT_S.
- XLEN=64:
  - lui 0x12345 (0x123452B7) -> out_imm=0x0000000012345000, fmt=FMT_U.
  - lui 0x80000 (0x800002B7) -> 0xFFFFFFFF80000000.
- Backpressure: out_ready=0, three back-to-back valid inputs tagged 1,2,3 -> tags 1,2 accepted and in_ready=0 on the third. Raise out_ready -> tags 1,2,3 emerge in order on consecutive cycles, none lost or duplicated.
- Both entries full, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed and the concurrent input never appear. Repeat with rst -> outputs all zero.
- Opcode 0x7F -> illegal=1, imm=0.
- csrrwi x0,0xFFF,31 (0xFFFFD073):
  - With IMMGEN_ZIMM_EN -> imm=0x1F, fmt=FMT_Z.
  - Without it -> imm=0xFFFFFFFF, fmt=FMT_I.
